// File: rtl/modmul_pkg.sv
// modmul_pkg: types and latency derivation shared by
// the modular multiplier and its request scheduler.
package modmul_pkg;

    localparam int TAG_IDW = 8;

    typedef struct packed {
        logic [7:0] logq;
        logic [7:0] logqh;
        logic       correct;
    } modmul_params_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic modmul_params_t modmul_params(
        input int logq,
        input int logqh,
        input bit correct
    );
        modmul_params_t p;
        p.logq    = 8'(logq);
        p.logqh   = 8'(logqh);
        p.correct = correct;
        return p;
    endfunction

    // product, fold and output stages, plus extra
    // stages for wide operands, sparse moduli and
    // the final conditional subtraction
    function automatic int modmul_lat(input modmul_params_t p);
        int lat;
        lat = 3;
        if (p.logq > 8'd16) lat++;
        if (p.logqh < (p.logq >> 1)) lat++;
        if (p.correct) lat++;
        return lat;
    endfunction

endpackage

// File: rtl/modmul.sv
// modmul: fixed-latency modular multiplier,
// q = qH * 2^(LOGQ-LOGQH) + 1.
module modmul
    import modmul_pkg::*;
#(
    parameter int LOGQ    = 32,
    parameter int LOGQH   = 15,
    parameter bit CORRECT = 1'b1,
    parameter int LAT     = modmul_lat(modmul_params(LOGQ, LOGQH, CORRECT))
) (
    input  logic             clk,
    input  logic [LOGQH-1:0] qH,
    input  logic [LOGQ-1:0]  a,
    input  logic [LOGQ-1:0]  b,
    output logic [LOGQ-1:0]  t
);

    localparam int PW = 2 * LOGQ;

    logic [PW-1:0]   q;
    logic [PW-1:0]   m;
    logic [PW-1:0]   p;
    logic [LOGQ-1:0] pipe [LAT];

    // modulus and product; without correction only reduce mod 2q
    always_comb begin
        q = PW'({qH, {(LOGQ - LOGQH){1'b0}}}) + PW'(1);
        m = CORRECT ? q : (q << 1);
        p = PW'(a) * PW'(b);
    end

    // reduced product travels down a LAT-deep register chain
    always_ff @(posedge clk) begin
        pipe[0] <= LOGQ'(p % m);
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    assign t = pipe[LAT-1];

endmodule

// File: rtl/modmul_sched.sv
// modmul_sched: round-robin sharing of one modmul between
// NREQ requesters with credit-protected result FIFO.
module modmul_sched
    import modmul_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LOGQ  = 32,
    parameter int LOGQH = 15,
    parameter int LAT   = modmul_lat(modmul_params(LOGQ, LOGQH, 1'b1)),
    parameter int DEPTH = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LOGQH-1:0]     qH,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LOGQ-1:0] req_a,
    input  logic [NREQ*LOGQ-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [LOGQ-1:0]      res_t
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(DEPTH);

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [LOGQ-1:0] t;
    } ent_t;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic [IDW:0]    idx;
    logic            found;
    logic            issue;
    logic            acc;
    logic            pop;
    logic            wr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   fcnt;
    logic [FW-1:0]   wp;
    logic [FW-1:0]   rp;
    logic [LOGQ-1:0] a_q;
    logic [LOGQ-1:0] b_q;
    logic [LOGQ-1:0] mm_t;
    tag_t            tag [LAT+1];
    ent_t            mem [DEPTH];

    assign issue = cnt < CW'(DEPTH);
    assign acc   = found & issue;
    assign pop   = res_valid & res_ready;
    assign wr    = tag[LAT].valid;

    // first valid requester at or after ptr gets the grant
    always_comb begin
        req_ready = '0;
        gid       = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                gid   = idx[IDW-1:0];
            end
        end
        req_ready[gid] = found & issue;
    end

    // priority pointer and credit count
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            if (acc) ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            if (acc && !pop) cnt <= cnt + 1'b1;
            else if (pop && !acc) cnt <= cnt - 1'b1;
        end
    end

    // issue registers feeding the multiplier
    always_ff @(posedge clk) begin
        if (acc) begin
            a_q <= req_a[gid*LOGQ +: LOGQ];
            b_q <= req_b[gid*LOGQ +: LOGQ];
        end
    end

    // tag pipe shadows the multiplier; stage LAT meets its output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) tag[k] <= '0;
        end else begin
            tag[0].valid <= acc;
            tag[0].id    <= TAG_IDW'(gid);
            for (int k = 1; k <= LAT; k++) tag[k] <= tag[k-1];
        end
    end

    modmul #(
        .LOGQ   (LOGQ),
        .LOGQH  (LOGQH),
        .CORRECT(1'b1),
        .LAT    (LAT)
    ) u_mm (
        .clk(clk),
        .qH (qH),
        .a  (a_q),
        .b  (b_q),
        .t  (mm_t)
    );

    // result storage
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= '{id: IDW'(tag[LAT].id), t: mm_t};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (wr) wp <= (wp == FW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop) rp <= (rp == FW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            if (wr && !pop) fcnt <= fcnt + 1'b1;
            else if (pop && !wr) fcnt <= fcnt - 1'b1;
        end
    end

    // credits must keep every write clear of a full FIFO
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            assert (fcnt != CW'(DEPTH));
            assert (tag[LAT].id < TAG_IDW'(NREQ));
        end
    end

    assign res_valid = fcnt != '0;
    assign res_id    = res_valid ? mem[rp].id : '0;
    assign res_t     = res_valid ? mem[rp].t : '0;

endmodule

// File: tb/tb_modmul_sched.sv
// tb_modmul_sched: directed and soak checks of the
// scheduler against hand values and a reference model.
module tb_modmul_sched;

    localparam int NREQ  = 4;
    localparam int LOGQ  = 32;
    localparam int LOGQH = 15;
    localparam int LAT   = 6;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [LOGQH-1:0]     qH;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*LOGQ-1:0] req_a;
    logic [NREQ*LOGQ-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [1:0]           res_id;
    logic [LOGQ-1:0]      res_t;

    modmul_sched #(
        .NREQ (NREQ),
        .LOGQ (LOGQ),
        .LOGQH(LOGQH),
        .LAT  (LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .qH       (qH),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_t    (res_t)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gold(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [14:0] qh);
        logic [63:0] q;
        q = (64'(qh) << 17) + 64'd1;
        return 32'((64'(a) * 64'(b)) % q);
    endfunction

    typedef struct {
        logic [1:0]  id;
        logic [31:0] t;
    } ent_t;

    ent_t        sb[$];
    int          acc_id[$];
    int          acc_cyc[$];
    int          pop_id[$];
    int          pop_cyc[$];
    logic [31:0] pop_t[$];
    int          cyc = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [3:0]  last_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // observe grants and pops, keep the scoreboard
    always @(negedge clk) begin
        ent_t e;
        last_acc = req_valid & req_ready;
        if (rst) begin
            sb.delete();
            last_acc = '0;
        end else begin
            chk("grant_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (last_acc[i]) begin
                    e.id = 2'(i);
                    e.t  = gold(req_a[i*32 +: 32], req_b[i*32 +: 32], qH);
                    sb.push_back(e);
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                    n_acc++;
                end
            end
            if (res_valid && res_ready) begin
                n_pop++;
                pop_id.push_back(int'(res_id));
                pop_t.push_back(res_t);
                pop_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 64'(res_id), 64'(e.id));
                    chk("sb_t", 64'(res_t), 64'(e.t));
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        acc_id.delete();
        acc_cyc.delete();
        pop_id.delete();
        pop_cyc.delete();
        pop_t.delete();
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while ((res_valid || sb.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] hand [4];
    logic        seen;
    int          bad;
    int          base_acc;
    int          base_pop;

    initial begin
        hand[0] = 32'd6;
        hand[1] = 32'h40000;
        hand[2] = 32'h60000;
        hand[3] = 32'h5FFFF;
        rst       = 1'b1;
        qH        = 15'h3;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_t", 64'(res_t), 64'd0);
        tick();
        rst = 1'b0;

        // single op from requester 2
        set_op(2, 32'd0, 32'h1234);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        seen = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k <= LAT + 1) seen |= res_valid;
        end
        chk("single_early", 64'(seen), 64'd0);
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_id", 64'(res_id), 64'd2);
        chk("single_t", 64'(res_t), 64'd0);
        wait_drain("single_drain", 20);

        // full contention
        do_reset();
        clear_logs();
        set_op(0, 32'd2, 32'd3);
        set_op(1, 32'h10000, 32'd4);
        set_op(2, 32'h20000, 32'd3);
        set_op(3, 32'h20000, 32'd6);
        req_valid = '1;
        res_ready = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        wait_drain("rr_drain", 40);
        chk("rr_count", 64'(acc_id.size()), 64'd12);
        chk("res_count", 64'(pop_id.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < acc_id.size())
                chk("rr_id", 64'(acc_id[i]), 64'(i % 4));
            if (i < pop_id.size()) begin
                chk("res_id", 64'(pop_id[i]), 64'(i % 4));
                chk("res_t", 64'(pop_t[i]), 64'(hand[i % 4]));
            end
        end
        if (acc_cyc.size() == 12)
            chk("rr_b2b", 64'(acc_cyc[11] - acc_cyc[0]), 64'd11);
        if (pop_cyc.size() == 12) begin
            chk("res_b2b", 64'(pop_cyc[11] - pop_cyc[0]), 64'd11);
            chk("res_lat", 64'(pop_cyc[0] - acc_cyc[0]), 64'(LAT + 2));
        end

        // backpressure on requester 1
        do_reset();
        clear_logs();
        set_op(1, 32'd2, 32'd3);
        res_ready = 1'b0;
        req_valid = 4'b0010;
        repeat (DEPTH + LAT + 4) tick();
        @(negedge clk);
        chk("bp_accepts", 64'(acc_id.size()), 64'(DEPTH));
        chk("bp_stall", 64'(req_ready), 64'd0);
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_noacc", 64'(req_ready), 64'd0);
        chk("full_pop_valid", 64'(res_valid), 64'd1);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_acc", 64'(req_ready), 64'b0010);
        tick();
        @(negedge clk);
        chk("cnt_full_again", 64'(req_ready), 64'd0);
        chk("bp_accepts2", 64'(acc_id.size()), 64'(DEPTH + 1));
        tick();
        req_valid = '0;
        res_ready = 1'b1;
        wait_drain("bp_drain", 60);
        chk("bp_pops", 64'(pop_id.size()), 64'(DEPTH + 1));
        bad = 0;
        foreach (pop_id[i]) if (pop_id[i] != 1) bad++;
        chk("bp_ids", 64'(bad), 64'd0);

        // reset with operations in flight
        tick();
        res_ready = 1'b0;
        req_valid = '1;
        repeat (5) tick();
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            seen |= res_valid;
        end
        chk("rst_flush", 64'(seen), 64'd0);
        tick();
        clear_logs();
        req_valid = '1;
        @(negedge clk);
        chk("rst_ptr", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        wait_drain("rst_drain", 20);
        chk("rst_pop_n", 64'(pop_id.size()), 64'd1);

        // random soak
        qH = 15'h5A5;
        base_acc = n_acc;
        base_pop = n_pop;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, $urandom, $urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_drain("soak_drain", 100);
        chk("soak_balance", 64'(n_pop - base_pop), 64'(n_acc - base_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
